// File: rtl/lan_local_parser_pkg.sv
// Shared control API header for the LAN local parser: stream widths, header
// field offsets within the first beat, and the parser state encoding.
package lan_local_parser_pkg;

   localparam int AXIS_DATA_WIDTH_DEF      = 512;
   localparam int AXIS_KEEP_WIDTH_DEF      = AXIS_DATA_WIDTH_DEF / 8;
   localparam int AXIS_LAN_TDEST_WIDTH_DEF = 8;
   localparam int IP_ADDRESS_WIDTH_DEF     = 32;
   localparam int IP_PORT_WIDTH_DEF        = 16;
   localparam int DROP_COUNT_WIDTH         = 32;

   // Bit offsets of the routing fields inside the header beat's tdata
   localparam int HDR_IP_LSB    = 0;
   localparam int HDR_PORT_LSB  = 32;
   localparam int HDR_TDEST_LSB = 48;

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } parser_state_e;

endpackage

// File: rtl/lan_local_parser_if.sv
// AXI-Stream bundle (tvalid/tready/tdata/tkeep/tid/tdest/tlast) used on both
// sides of the LAN local parser.
interface lan_local_parser_if
   import lan_local_parser_pkg::*;
#(
   parameter int DATA_WIDTH  = AXIS_DATA_WIDTH_DEF,
   parameter int KEEP_WIDTH  = AXIS_KEEP_WIDTH_DEF,
   parameter int TDEST_WIDTH = AXIS_LAN_TDEST_WIDTH_DEF
) ();

   logic                   tvalid;
   logic                   tready;
   logic [DATA_WIDTH-1:0]  tdata;
   logic [KEEP_WIDTH-1:0]  tkeep;
   logic [TDEST_WIDTH-1:0] tid;
   logic [TDEST_WIDTH-1:0] tdest;
   logic                   tlast;

   modport master (
      output tvalid, tdata, tkeep, tid, tdest, tlast,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tkeep, tid, tdest, tlast,
      output tready
   );

endinterface

// File: rtl/lan_local_parser.sv
// Strips the routing header off each packet from the switch and forwards the
// payload to the router when the header addresses this node; everything else is
// discarded. Optional drop counter enabled by LAN_PARSER_DROP_COUNT_EN.
module lan_local_parser
   import lan_local_parser_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH      = AXIS_DATA_WIDTH_DEF,
   parameter int AXIS_KEEP_WIDTH      = AXIS_KEEP_WIDTH_DEF,
   parameter int AXIS_LAN_TDEST_WIDTH = AXIS_LAN_TDEST_WIDTH_DEF,
   parameter int IP_ADDRESS_WIDTH     = IP_ADDRESS_WIDTH_DEF,
   parameter int IP_PORT_WIDTH        = IP_PORT_WIDTH_DEF
) (
   input  logic                        i_clk,
   input  logic                        i_ap_rst,
   input  logic [IP_ADDRESS_WIDTH-1:0] i_local_ip_address,
   input  logic [IP_PORT_WIDTH-1:0]    i_LAN_port_number,
   lan_local_parser_if.slave           from_switch,
   lan_local_parser_if.master          to_router,
   output logic [DROP_COUNT_WIDTH-1:0] o_drop_count
);

   parser_state_e state_reg, state_next;

   logic [AXIS_LAN_TDEST_WIDTH-1:0] tid_reg;
   logic [AXIS_LAN_TDEST_WIDTH-1:0] tdest_reg;

   logic                            out_tvalid_reg;
   logic [AXIS_DATA_WIDTH-1:0]      out_tdata_reg;
   logic [AXIS_KEEP_WIDTH-1:0]      out_tkeep_reg;
   logic                            out_tlast_reg;
   logic [AXIS_LAN_TDEST_WIDTH-1:0] out_tid_reg;
   logic [AXIS_LAN_TDEST_WIDTH-1:0] out_tdest_reg;

   logic in_ready;
   logic fwd_ready;
   logic hdr_match;
   logic latch_hdr;
   logic load_out;
   logic count_drop;

   assign hdr_match =
      (from_switch.tdata[HDR_IP_LSB +: IP_ADDRESS_WIDTH] == i_local_ip_address) &&
      (from_switch.tdata[HDR_PORT_LSB +: IP_PORT_WIDTH] == i_LAN_port_number);

   // Output slot may be refilled in the same cycle it drains
   assign fwd_ready = !out_tvalid_reg || to_router.tready;

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      latch_hdr  = 1'b0;
      load_out   = 1'b0;
      count_drop = 1'b0;
      case (state_reg)
         ST_HDR: begin
            in_ready = 1'b1;
            if (from_switch.tvalid) begin
               if (from_switch.tlast) begin
                  count_drop = 1'b1;
               end else if (hdr_match) begin
                  latch_hdr  = 1'b1;
                  state_next = ST_FWD;
               end else begin
                  state_next = ST_DROP;
               end
            end
         end
         ST_FWD: begin
            in_ready = fwd_ready;
            if (from_switch.tvalid && fwd_ready) begin
               load_out = 1'b1;
               if (from_switch.tlast) begin
                  state_next = ST_HDR;
               end
            end
         end
         ST_DROP: begin
            in_ready = 1'b1;
            if (from_switch.tvalid && from_switch.tlast) begin
               count_drop = 1'b1;
               state_next = ST_HDR;
            end
         end
         default: begin
            state_next = ST_HDR;
         end
      endcase
   end

   assign from_switch.tready = in_ready && !i_ap_rst;

   always_ff @(posedge i_clk) begin
      if (i_ap_rst) begin
         state_reg      <= ST_HDR;
         tid_reg        <= '0;
         tdest_reg      <= '0;
         out_tvalid_reg <= 1'b0;
         out_tid_reg    <= '0;
         out_tdest_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (latch_hdr) begin
            tid_reg   <= from_switch.tid;
            tdest_reg <= from_switch.tdata[HDR_TDEST_LSB +: AXIS_LAN_TDEST_WIDTH];
         end
         // Routing tags travel with the beat so a stalled last beat keeps its
         // tags while the next header is already being latched.
         if (load_out) begin
            out_tvalid_reg <= 1'b1;
            out_tid_reg    <= tid_reg;
            out_tdest_reg  <= tdest_reg;
         end else if (to_router.tready) begin
            out_tvalid_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (load_out) begin
         out_tdata_reg <= from_switch.tdata;
         out_tkeep_reg <= from_switch.tkeep;
         out_tlast_reg <= from_switch.tlast;
      end
   end

   assign to_router.tvalid = out_tvalid_reg;
   assign to_router.tdata  = out_tdata_reg;
   assign to_router.tkeep  = out_tkeep_reg;
   assign to_router.tlast  = out_tlast_reg;
   assign to_router.tid    = out_tid_reg;
   assign to_router.tdest  = out_tdest_reg;

   // Incoming tdest is not part of the routing decision
   logic unused_in_tdest;
   assign unused_in_tdest = ^from_switch.tdest;

`ifdef LAN_PARSER_DROP_COUNT_EN
   logic [DROP_COUNT_WIDTH-1:0] drop_count_reg;

   always_ff @(posedge i_clk) begin
      if (i_ap_rst) begin
         drop_count_reg <= '0;
      end else if (count_drop && (drop_count_reg != {DROP_COUNT_WIDTH{1'b1}})) begin
         drop_count_reg <= drop_count_reg + 1'b1;
      end
   end

   assign o_drop_count = drop_count_reg;
`else
   logic unused_count_drop;
   assign unused_count_drop = count_drop;
   assign o_drop_count      = '0;
`endif

endmodule
